// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Produces pixel/line counters, sync, blanking, an active-video flag, start
// strobes and a frame counter. Every output is registered from the same
// "next" counter values, so flags and counters always describe the same pixel.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_ACTIVE  = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int PIX_DIV   = 1,
   parameter int CNT_W     = 11,
   parameter int FRAME_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               hblnk,
   output logic               vblnk,
   output logic               active,
   output logic               pix_ce,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_BLANK  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_BLANK  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [4:0]       PRE_LAST = 5'(PIX_DIV - 1);

   // Reject timings that cannot be generated correctly.
   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $fatal(1, "vga_timing_gen: active, porch and sync widths must be non-zero");
   end
   if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
      $fatal(1, "vga_timing_gen: PIX_DIV must be in 1..16");
   end
   if (CNT_W < 1 || CNT_W > 30 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
      $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
   end

   logic [4:0]       prescaler;
   logic             adv;
   logic             h_wrap;
   logic             v_wrap;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   logic             in_hs;
   logic             in_vs;
   logic             hb_nxt;
   logic             vb_nxt;

   // Next counter values and the flags that describe them.
   always_comb begin
      adv    = en && (prescaler == PRE_LAST);
      h_wrap = (hcount == H_LAST);
      v_wrap = (vcount == V_LAST);
      h_nxt  = hcount;
      v_nxt  = vcount;
      if (adv) begin
         h_nxt = h_wrap ? '0 : hcount + CNT_W'(1);
         if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount + CNT_W'(1);
         end
      end
      hb_nxt = (h_nxt >= H_BLANK);
      vb_nxt = (v_nxt >= V_BLANK);
      in_hs  = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
      in_vs  = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
   end

   // State register: prescaler, counters, flags and strobes update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler   <= '0;
         hcount      <= '0;
         vcount      <= '0;
         frame_cnt   <= '0;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         active      <= 1'b1;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         pix_ce      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (en) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 5'd1;
         end
         hcount <= h_nxt;
         vcount <= v_nxt;
         if (adv && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
         end
         hblnk       <= hb_nxt;
         vblnk       <= vb_nxt;
         active      <= !hb_nxt && !vb_nxt;
         hsync       <= in_hs ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= in_vs ? VSYNC_POL : ~VSYNC_POL;
         pix_ce      <= adv;
         line_start  <= adv && h_wrap;
         frame_start <= adv && h_wrap && v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: four parameterisations share clk,
// rst and en; a linear pixel-index reference model predicts every output.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst;
   logic en;

   always #5 clk = ~clk;

   typedef struct {
      int ha, hf, hs, hb;
      int va, vf, vs, vb;
      bit hp, vp;
      int div;
      int fw;
   } cfg_t;

   localparam int N = 4;

   cfg_t  cfg [N];
   string nm  [N];
   int    pos [N];
   int    ph  [N];
   int    fr  [N];
   bit    ce_m[N];
   bit    ls_m[N];
   bit    fs_m[N];

   logic [31:0] o_hc[N];
   logic [31:0] o_vc[N];
   logic [31:0] o_fc[N];
   logic [7:0]  o_fl[N];

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- instances ----------------
   logic [10:0] d_hc, d_vc;  logic [15:0] d_fc;
   logic d_hs, d_vs, d_hb, d_vb, d_ac, d_ce, d_ls, d_fs;
   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .en(en), .hcount(d_hc), .vcount(d_vc),
      .hsync(d_hs), .vsync(d_vs), .hblnk(d_hb), .vblnk(d_vb), .active(d_ac),
      .pix_ce(d_ce), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc));

   logic [10:0] g_hc, g_vc;  logic [15:0] g_fc;
   logic g_hs, g_vs, g_hb, g_vb, g_ac, g_ce, g_ls, g_fs;
   vga_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_vga (
      .clk(clk), .rst(rst), .en(en), .hcount(g_hc), .vcount(g_vc),
      .hsync(g_hs), .vsync(g_vs), .hblnk(g_hb), .vblnk(g_vb), .active(g_ac),
      .pix_ce(g_ce), .line_start(g_ls), .frame_start(g_fs), .frame_cnt(g_fc));

   logic [10:0] a_hc, a_vc;  logic [3:0] a_fc;
   logic a_hs, a_vs, a_hb, a_vb, a_ac, a_ce, a_ls, a_fs;
   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .FRAME_W(4)) u_s1 (
      .clk(clk), .rst(rst), .en(en), .hcount(a_hc), .vcount(a_vc),
      .hsync(a_hs), .vsync(a_vs), .hblnk(a_hb), .vblnk(a_vb), .active(a_ac),
      .pix_ce(a_ce), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));

   logic [3:0] b_hc, b_vc;  logic [2:0] b_fc;
   logic b_hs, b_vs, b_hb, b_vb, b_ac, b_ce, b_ls, b_fs;
   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(4),
                    .CNT_W(4), .FRAME_W(3)) u_s4 (
      .clk(clk), .rst(rst), .en(en), .hcount(b_hc), .vcount(b_vc),
      .hsync(b_hs), .vsync(b_vs), .hblnk(b_hb), .vblnk(b_vb), .active(b_ac),
      .pix_ce(b_ce), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));

   assign o_hc[0] = 32'(d_hc);  assign o_vc[0] = 32'(d_vc);  assign o_fc[0] = 32'(d_fc);
   assign o_hc[1] = 32'(g_hc);  assign o_vc[1] = 32'(g_vc);  assign o_fc[1] = 32'(g_fc);
   assign o_hc[2] = 32'(a_hc);  assign o_vc[2] = 32'(a_vc);  assign o_fc[2] = 32'(a_fc);
   assign o_hc[3] = 32'(b_hc);  assign o_vc[3] = 32'(b_vc);  assign o_fc[3] = 32'(b_fc);
   assign o_fl[0] = {d_hs, d_vs, d_hb, d_vb, d_ac, d_ce, d_ls, d_fs};
   assign o_fl[1] = {g_hs, g_vs, g_hb, g_vb, g_ac, g_ce, g_ls, g_fs};
   assign o_fl[2] = {a_hs, a_vs, a_hb, a_vb, a_ac, a_ce, a_ls, a_fs};
   assign o_fl[3] = {b_hs, b_vs, b_hb, b_vb, b_ac, b_ce, b_ls, b_fs};

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: the raster is a linear pixel index; row/column follow by division.
   task automatic step(input int k, input bit r, input bit e);
      int ht, vt;
      ht = cfg[k].ha + cfg[k].hf + cfg[k].hs + cfg[k].hb;
      vt = cfg[k].va + cfg[k].vf + cfg[k].vs + cfg[k].vb;
      ce_m[k] = 1'b0;
      ls_m[k] = 1'b0;
      fs_m[k] = 1'b0;
      if (r) begin
         pos[k] = 0;
         ph[k]  = 0;
         fr[k]  = 0;
      end else if (e) begin
         if (ph[k] == cfg[k].div - 1) begin
            ph[k]   = 0;
            ce_m[k] = 1'b1;
            pos[k]  = (pos[k] + 1) % (ht * vt);
            ls_m[k] = (pos[k] % ht) == 0;
            fs_m[k] = (pos[k] == 0);
            if (fs_m[k]) fr[k]++;
         end else begin
            ph[k]++;
         end
      end
   endtask

   task automatic check_inst(input int k);
      int  ht, h, v;
      bit  hb, vb, hsa, vsa;
      ht  = cfg[k].ha + cfg[k].hf + cfg[k].hs + cfg[k].hb;
      h   = pos[k] % ht;
      v   = pos[k] / ht;
      hb  = h >= cfg[k].ha;
      vb  = v >= cfg[k].va;
      hsa = (h >= cfg[k].ha + cfg[k].hf) && (h < cfg[k].ha + cfg[k].hf + cfg[k].hs);
      vsa = (v >= cfg[k].va + cfg[k].vf) && (v < cfg[k].va + cfg[k].vf + cfg[k].vs);
      chk({nm[k], ".hcount"},      64'(o_hc[k]), 64'(h));
      chk({nm[k], ".vcount"},      64'(o_vc[k]), 64'(v));
      chk({nm[k], ".frame_cnt"},   64'(o_fc[k]), 64'(fr[k] % (1 << cfg[k].fw)));
      chk({nm[k], ".hsync"},       64'(o_fl[k][7]), 64'(hsa ? cfg[k].hp : !cfg[k].hp));
      chk({nm[k], ".vsync"},       64'(o_fl[k][6]), 64'(vsa ? cfg[k].vp : !cfg[k].vp));
      chk({nm[k], ".hblnk"},       64'(o_fl[k][5]), 64'(hb));
      chk({nm[k], ".vblnk"},       64'(o_fl[k][4]), 64'(vb));
      chk({nm[k], ".active"},      64'(o_fl[k][3]), 64'(!hb && !vb));
      chk({nm[k], ".pix_ce"},      64'(o_fl[k][2]), 64'(ce_m[k]));
      chk({nm[k], ".line_start"},  64'(o_fl[k][1]), 64'(ls_m[k]));
      chk({nm[k], ".frame_start"}, 64'(o_fl[k][0]), 64'(fs_m[k]));
   endtask

   // Stimulus: reset, free run with a 10-cycle pause at column 500, then random en/rst.
   initial begin
      int  pause_left;
      bit  pause_done;
      bit  rst_done;
      cfg[0] = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 1, 16};
      cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, 16};
      cfg[2] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 1, 4};
      cfg[3] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 4, 3};
      nm[0] = "def";  nm[1] = "vga640";  nm[2] = "small";  nm[3] = "small_div4";
      pause_left = 0;
      pause_done = 1'b0;
      rst_done   = 1'b0;
      rst = 1'b1;
      en  = 1'b1;
      for (int k = 0; k < N; k++) step(k, 1'b1, 1'b1);
      for (int c = 0; c < 40000; c++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) check_inst(k);
         if (c == 0) begin
            rst = 1'b1;
            en  = 1'b1;
         end else if (pause_left > 0) begin
            rst = 1'b0;
            en  = 1'b0;
            pause_left--;
         end else if (!pause_done && pos[0] == 500) begin
            rst = 1'b0;
            en  = 1'b0;
            pause_left = 9;
            pause_done = 1'b1;
         end else if (c < 700) begin
            rst = 1'b0;
            en  = 1'b1;
         end else begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 7999) == 0);
            if (!rst_done && c > 20000 && pos[2] == 3 * 15 + 5) begin
               rst      = 1'b1;
               rst_done = 1'b1;
            end
         end
         for (int k = 0; k < N; k++) step(k, rst, en);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA timing generator.
- Produces hcount/vcount, sync and blanking for any resolution set by parameters, with selectable sync polarity and an internal pixel-clock-enable divider.
- Adds frame/line start strobes, an active-video flag and a frame counter.
- Sits at the head of the video pipeline and feeds the draw/overlay stages.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, asserted level of hsync (1 = active-high, 0 = active-low)
- VSYNC_POL, 1, asserted level of vsync
- PIX_DIV, 1, clk cycles per pixel (1..16)
- CNT_W, 11, hcount/vcount width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 16, frame counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable; when 0, all state frozen
- hcount  out  CNT_W  current pixel column
- vcount  out  CNT_W  current line
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- hblnk  out  1  horizontal blanking, active-high
- vblnk  out  1  vertical blanking, active-high
- active  out  1  !hblnk && !vblnk
- pix_ce  out  1  one-clk pulse: counters advance this cycle
- line_start  out  1  one-clk pulse when hcount becomes 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) becomes (0,0)
- frame_cnt  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628)
- Reset (rst=1 at posedge), all outputs cleared:
  - Counters: hcount=0, vcount=0, prescaler=0, frame_cnt=0.
  - Flags: hblnk=0, vblnk=0, active=1, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - Strobes: pix_ce=0, line_start=0, frame_start=0.
  - rst overrides en.
- Prescaler:
  - Counts 0..PIX_DIV-1 on each clk with en=1.
  - Advance condition: adv = en && prescaler==PIX_DIV-1.
  - PIX_DIV=1 gives adv=en every cycle.
- Counter update on adv:
  - hcount == H_TOTAL-1: hcount <= 0.
  - Otherwise: hcount <= hcount+1.
  - When hcount wraps:
    - vcount == V_TOTAL-1: vcount <= 0.
    - Otherwise: vcount <= vcount+1.
  - frame_cnt increments when both counters wrap in the same adv.
  - No change on cycles without adv.
- All outputs are registered and consistent with the hcount/vcount value presented in the same cycle (zero skew between counters and flags):
  - hblnk = hcount in [H_ACTIVE, H_TOTAL-1].
  - vblnk = vcount in [V_ACTIVE, V_TOTAL-1].
  - hsync asserted (=HSYNC_POL) iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted (=VSYNC_POL) iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - vsync is independent of hcount; it changes only on the hcount wrap.
- Strobes (each high exactly one clk, in the cycle the new counter value first appears):
  - pix_ce: registered adv.
  - line_start: hcount changed to 0.
  - frame_start: (0,0) reached by wrap only; none after reset.
- en=0 mid-line: prescaler, counters, flags and frame_cnt hold; strobes forced 0. Resume continues exactly where it stopped.
- Reset mid-frame: next cycle matches the reset state; the first advance goes to hcount=1.
- Parameter legality: elaboration fatal if any porch/sync/active value is 0, PIX_DIV is outside 1..16, or CNT_W is too narrow.

Test Plan:
- Defaults, rst pulse for 2 clk, en=1:
  - During reset: hcount=vcount=0, hsync=vsync=0.
  - After release: hcount steps 0,1,2..., each step with pix_ce=1.
- Defaults, run to hcount=1055:
  - Next cycle: hcount=0, vcount+1, line_start=1.
  - hblnk=1 exactly for hcount 800..1055.
  - hsync=1 exactly for hcount 840..967.
- Defaults, run two full frames:
  - (1055,627) -> (0,0) with frame_start=1; frame_cnt increments 0->1->2.
  - vsync=1 exactly for vcount 601..604.
  - vblnk=1 exactly for vcount 600..627.
- HSYNC_POL=0, VSYNC_POL=0, 640x480 (16/96/48, 10/2/33):
  - H_TOTAL=800, V_TOTAL=525.
  - hsync=0 only for hcount 656..751, else 1.
  - vsync=0 only for vcount 490..491.
- PIX_DIV=4: hcount advances every 4th clk; pix_ce high 1 of 4 cycles; line period = 4*H_TOTAL clk.
- Control mid-operation, default parameters:
  - Drop en for 10 clk at hcount=500: all outputs hold; resume at 501.
  - Assert rst at (300,200): next cycle (0,0), frame_cnt=0, frame_start=0.
